// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Build option: define RESET_SEQ_EXT_EN to enable the external reset pin path.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_EXT = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Two-flop synchronizer for the external active-low reset pin.
// Flops come up in the asserted (0) state so the pin reads as "in reset"
// until two clean high samples have been taken.
module reset_seq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw pin through two flops to settle metastability.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: stretches a reset request, then releases N_DOMAINS
// active-low domain resets one after another, STAGGER cycles apart.
// Build option: RESET_SEQ_EXT_EN adds a synchronized ext_rst_n trigger;
// without it the pin is ignored and cause[3] stays 0.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS = 3,
  parameter int STRETCH   = 16,
  parameter int STAGGER   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n_in,
  input  logic                 sw_rst_req,
  input  logic                 wdt_expire,
  input  logic                 ext_rst_n,
  input  logic                 cause_clr,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 rst_busy,
  output logic [3:0]           cause
);

  localparam int CNT_W = $clog2(max2(STRETCH, STAGGER));
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOMAINS - 1);

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [N_DOMAINS-1:0] r_rst_n_out, w_rst_n_out_nxt;
  logic [3:0]           r_cause;

  logic       w_ext_trig;
  logic [3:0] w_trig_vec;
  logic       w_trig;

`ifdef RESET_SEQ_EXT_EN
  logic w_ext_sync_n;

  reset_seq_sync u_ext_sync (
    .clk     (clk),
    .rst_n   (rst_n_in),
    .i_async (ext_rst_n),
    .o_sync  (w_ext_sync_n)
  );

  // A synchronized low level is a continuous trigger.
  assign w_ext_trig = ~w_ext_sync_n;
`else
  logic w_unused_ext;
  assign w_unused_ext = ext_rst_n;
  assign w_ext_trig   = 1'b0;
`endif

  assign w_trig_vec[CAUSE_POR] = 1'b0;
  assign w_trig_vec[CAUSE_SW]  = sw_rst_req;
  assign w_trig_vec[CAUSE_WDT] = wdt_expire;
  assign w_trig_vec[CAUSE_EXT] = w_ext_trig;
  assign w_trig                = |w_trig_vec;

  // State, counter, domain index and the domain reset outputs themselves.
  // NOTE: rst_n_in is an asynchronous reset, so it sits in the sensitivity
  // list; outputs drop immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n_out <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_n_out <= w_rst_n_out_nxt;
    end
  end

  // Next-state logic: any trigger restarts HOLD; otherwise count and step.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rst_n_out_nxt = r_rst_n_out;
    if (w_trig) begin
      w_state_nxt     = HOLD;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
      w_rst_n_out_nxt = '0;
    end else begin
      unique case (r_state)
        HOLD: begin
          if (r_cnt == STRETCH_LAST) begin
            w_rst_n_out_nxt[0] = 1'b1;
            w_cnt_nxt          = '0;
            w_idx_nxt          = IDX_W'(1);
            w_state_nxt        = (N_DOMAINS == 1) ? RUN : RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_cnt == STAGGER_LAST) begin
            w_rst_n_out_nxt[r_idx] = 1'b1;
            w_cnt_nxt              = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = RUN;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RUN:     ;
        default: w_state_nxt = HOLD;
      endcase
    end
  end

  // Sticky cause flags: POR on power-up reset, triggers OR in, clear loses
  // to a trigger arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cause <= 4'b0001;
    end else if (cause_clr) begin
      r_cause <= w_trig_vec;
    end else begin
      r_cause <= r_cause | w_trig_vec;
    end
  end

  assign rst_n_out = r_rst_n_out;
  assign rst_busy  = ~&r_rst_n_out;
  assign cause     = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (N_DOMAINS=3, STRETCH=16, STAGGER=4).
// Edge numbers count rising clk edges after rst_n_in is first released.
module tb_reset_seq;

`ifdef RESET_SEQ_EXT_EN
  localparam int         S     = 2;        // sync flops restart HOLD twice
  localparam logic [3:0] POR_C = 4'b1001;
`else
  localparam int         S     = 0;
  localparam logic [3:0] POR_C = 4'b0001;
`endif

  logic       clk = 1'b0;
  logic       rst_n_in;
  logic       sw_rst_req;
  logic       wdt_expire;
  logic       ext_rst_n;
  logic       cause_clr;
  logic [2:0] rst_n_out;
  logic       rst_busy;
  logic [3:0] cause;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  reset_seq #(.N_DOMAINS(3), .STRETCH(16), .STAGGER(4)) dut (
    .clk        (clk),
    .rst_n_in   (rst_n_in),
    .sw_rst_req (sw_rst_req),
    .wdt_expire (wdt_expire),
    .ext_rst_n  (ext_rst_n),
    .cause_clr  (cause_clr),
    .rst_n_out  (rst_n_out),
    .rst_busy   (rst_busy),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] exp_out, input logic exp_busy);
    check({tag, "_out"}, 8'(rst_n_out), 8'(exp_out));
    check({tag, "_busy"}, 8'(rst_busy), 8'(exp_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) tick();
  endtask

  // Drive a one-cycle pulse so it is sampled exactly at edge e.
  task automatic pulse(input int e, input logic sw, input logic wdt, input logic clr);
    run_to(e - 1);
    sw_rst_req = sw;
    wdt_expire = wdt;
    cause_clr  = clr;
    tick();
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    cause_clr  = 1'b0;
  endtask

  initial begin
    rst_n_in   = 1'b0;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    ext_rst_n  = 1'b1;
    cause_clr  = 1'b0;

    // Power-on reset held for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    chk_out("por_held", 3'b000, 1'b1);
    check("por_held_cause", 8'(cause), 8'(4'b0001));
    rst_n_in = 1'b1;

    run_to(15 + S); chk_out("por_e15", 3'b000, 1'b1);
    run_to(16 + S); chk_out("por_e16", 3'b001, 1'b1);
    run_to(19 + S); chk_out("por_e19", 3'b001, 1'b1);
    run_to(20 + S); chk_out("por_e20", 3'b011, 1'b1);
    run_to(23 + S); chk_out("por_e23", 3'b011, 1'b1);
    run_to(24 + S); chk_out("por_e24", 3'b111, 1'b0);
    check("por_cause", 8'(cause), 8'(POR_C));

    // Simultaneous sw + wdt + clear: triggers win over clear, one sequence.
    pulse(100, 1'b1, 1'b1, 1'b1);
    chk_out("sim_e100", 3'b000, 1'b1);
    check("sim_cause", 8'(cause), 8'(4'b0110));
    run_to(115); chk_out("sim_e115", 3'b000, 1'b1);
    run_to(116); chk_out("sim_e116", 3'b001, 1'b1);
    run_to(120); chk_out("sim_e120", 3'b011, 1'b1);
    run_to(124); chk_out("sim_e124", 3'b111, 1'b0);

    pulse(130, 1'b0, 1'b0, 1'b1);
    check("clr_cause", 8'(cause), 8'(4'b0000));

    // Software reset from RUN.
    pulse(200, 1'b1, 1'b0, 1'b0);
    chk_out("sw_e200", 3'b000, 1'b1);
    check("sw_cause", 8'(cause), 8'(4'b0010));
    run_to(216); chk_out("sw_e216", 3'b001, 1'b1);
    run_to(220); chk_out("sw_e220", 3'b011, 1'b1);
    run_to(223); chk_out("sw_e223", 3'b011, 1'b1);
    run_to(224); chk_out("sw_e224", 3'b111, 1'b0);

    // Watchdog during RELEASE (bit 0 already up).
    pulse(300, 1'b1, 1'b0, 1'b0);
    run_to(317); chk_out("rel_e317", 3'b001, 1'b1);
    pulse(318, 1'b0, 1'b1, 1'b0);
    chk_out("rel_e318", 3'b000, 1'b1);
    check("rel_cause", 8'(cause), 8'(4'b0110));
    run_to(333); chk_out("rel_e333", 3'b000, 1'b1);
    run_to(334); chk_out("rel_e334", 3'b001, 1'b1);
    run_to(338); chk_out("rel_e338", 3'b011, 1'b1);
    run_to(342); chk_out("rel_e342", 3'b111, 1'b0);

    // A second trigger inside HOLD restarts the stretch.
    pulse(350, 1'b1, 1'b0, 1'b0);
    pulse(355, 1'b1, 1'b0, 1'b0);
    run_to(366); chk_out("hold_e366", 3'b000, 1'b1);
    run_to(370); chk_out("hold_e370", 3'b000, 1'b1);
    run_to(371); chk_out("hold_e371", 3'b001, 1'b1);
    run_to(379); chk_out("hold_e379", 3'b111, 1'b0);

    // External pin low for 10 sampled cycles (edges 400..409).
    run_to(399);
    ext_rst_n = 1'b0;
    run_to(409);
    ext_rst_n = 1'b1;
`ifdef RESET_SEQ_EXT_EN
    // Checks after the fact would miss 401/402, so they are re-run below.
`endif
    run_to(426);
`ifdef RESET_SEQ_EXT_EN
    chk_out("ext_e426", 3'b000, 1'b1);
    run_to(427); chk_out("ext_e427", 3'b001, 1'b1);
    run_to(435); chk_out("ext_e435", 3'b111, 1'b0);
    check("ext_cause", 8'(cause), 8'(4'b1110));
`else
    chk_out("ext_e426", 3'b111, 1'b0);
    run_to(435); chk_out("ext_e435", 3'b111, 1'b0);
    check("ext_cause", 8'(cause), 8'(4'b0110));
`endif

    // Second external pulse with edge-exact entry checks.
    run_to(439);
    ext_rst_n = 1'b0;
    run_to(441); chk_out("ext2_e441", 3'b111, 1'b0);
`ifdef RESET_SEQ_EXT_EN
    run_to(442); chk_out("ext2_e442", 3'b000, 1'b1);
`else
    run_to(442); chk_out("ext2_e442", 3'b111, 1'b0);
`endif
    run_to(443);
    ext_rst_n = 1'b1;
    run_to(480); chk_out("ext2_e480", 3'b111, 1'b0);

    pulse(490, 1'b0, 1'b0, 1'b1);
    check("clr2_cause", 8'(cause), 8'(4'b0000));

    // Asynchronous power-on reset mid-RELEASE, between clock edges.
    pulse(500, 1'b1, 1'b0, 1'b0);
    run_to(518); chk_out("mid_e518", 3'b001, 1'b1);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk_out("mid_async", 3'b000, 1'b1);
    check("mid_cause", 8'(cause), 8'(4'b0001));
    rst_n_in = 1'b1;
    run_to(518 + 15 + S); chk_out("mid_e15", 3'b000, 1'b1);
    run_to(518 + 16 + S); chk_out("mid_e16", 3'b001, 1'b1);
    run_to(518 + 20 + S); chk_out("mid_e20", 3'b011, 1'b1);
    run_to(518 + 24 + S); chk_out("mid_e24", 3'b111, 1'b0);
    check("mid_final_cause", 8'(cause), 8'(POR_C));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3: number of sequenced reset outputs, range 1..8.
REQ-002 SHALL have parameter STRETCH, default 16: minimum assert length in cycles, >= 2.
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive domain releases, >= 1.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n_in, input, 1: asynchronous, active-low reset; deasserted synchronously to clk by the upstream reset synchronizer.
REQ-006 SHALL have port sw_rst_req, input, 1: synchronous software reset request, one-cycle pulse.
REQ-007 SHALL have port wdt_expire, input, 1: synchronous watchdog reset request, one-cycle pulse.
REQ-008 SHALL have port ext_rst_n, input, 1: asynchronous, active-low external reset pin.
REQ-009 SHALL have port cause_clr, input, 1: synchronous clear of the cause register.
REQ-010 SHALL have port rst_n_out, output, N_DOMAINS: active-low domain resets; bit 0 is released first.
REQ-011 SHALL have port rst_busy, output, 1: high while any rst_n_out bit is low.
REQ-012 SHALL have port cause, output, 4: sticky cause flags, bit 0 POR, bit 1 SW, bit 2 WDT, bit 3 EXT.

Function
REQ-013 SHALL implement states HOLD (all domains asserted, counting STRETCH) → RELEASE (stepping domain index) → RUN (all released).
REQ-014 SHALL start HOLD with cnt=0; at each clk edge in HOLD, cnt increments; the edge where cnt==STRETCH-1 enters RELEASE and sets rst_n_out[0]=1.
REQ-015 SHALL, in RELEASE, set rst_n_out[i]=1 STAGGER edges after rst_n_out[i-1]; the edge releasing bit N_DOMAINS-1 enters RUN and clears rst_busy.
REQ-016 SHALL therefore release domain i after edge STRETCH + i*STAGGER, counted from the first edge in HOLD.
REQ-017 SHALL treat any trigger sampled high at edge k in RUN or RELEASE as follows: after edge k, all rst_n_out=0, rst_busy=1, state HOLD, cnt=0. This is a one-cycle registered latency.
REQ-018 SHALL restart cnt at 0 on any trigger sampled in HOLD, extending the assert.
REQ-019 SHALL treat an ext_rst_n level held low, after synchronization, as a continuous trigger: HOLD is held until it goes high, and STRETCH then counts from the first edge on which it is sampled high.
REQ-020 SHALL set cause[1], cause[2] and cause[3] on the edge their trigger is sampled; simultaneous triggers set all corresponding bits and start a single sequence.
REQ-021 SHALL clear cause to 4'b0000 on cause_clr; a trigger on the same edge wins and sets its bit.
REQ-022 SHALL keep cause unchanged by SW/WDT/EXT-initiated sequences, except for setting bits.
REQ-023 SHALL change rst_n_out only from registers, glitch-free, and drive them low only through async reset or REQ-017.

Reset
REQ-024 SHALL, while rst_n_in=0, asynchronously force rst_n_out to all zeros, rst_busy=1, state HOLD, cnt=0, domain index 0 and cause=4'b0001. This applies even mid-RELEASE or mid-RUN.
REQ-025 SHALL reset the ext_rst_n synchronizer flops to the asserted (0) value.

Configuration
REQ-026 SHALL, with RESET_SEQ_EXT_EN defined, pass ext_rst_n through a 2-flop synchronizer and treat it as a trigger per REQ-019, with 2 cycles of added latency.
REQ-027 SHALL, without RESET_SEQ_EXT_EN, keep the ext_rst_n port, ignore its value, omit the synchronizer, and tie cause[3] to 0.

Structure
REQ-028 SHALL place the state enum (HOLD/RELEASE/RUN) and the cause bit index constants (CAUSE_POR=0, CAUSE_SW=1, CAUSE_WDT=2, CAUSE_EXT=3) in package reset_seq_pkg.
REQ-029 SHALL implement the ext_rst_n 2-flop synchronizer as sub-module reset_seq_sync, instantiated only under RESET_SEQ_EXT_EN.

Verification (N_DOMAINS=3, STRETCH=16, STAGGER=4)
REQ-030 SHALL cover POR: rst_n_in low 5 cycles, then high before edge 1 → rst_n_out bits rise after edges 16/20/24, rst_busy falls after edge 24, cause=4'b0001.
REQ-031 SHALL cover SW reset: sw_rst_req pulse at edge 100 in RUN → rst_n_out=3'b000 after edge 100, bits rise after edges 116/120/124, cause=4'b0011; then cause_clr → cause=4'b0000.
REQ-032 SHALL cover trigger in RELEASE: wdt_expire at edge 118 (bit 0 up) → all bits low after edge 118, rise after edges 134/138/142, cause[2]=1.
REQ-033 SHALL cover simultaneous triggers: sw_rst_req, wdt_expire and cause_clr on the same edge → cause=4'b0110 and a single sequence, identical timing to REQ-031.
REQ-034 SHALL cover EXT: with the macro, ext_rst_n low 10 cycles in RUN → outputs low 3 edges after the fall, held, domain 0 rises 16 edges after the synchronized rise, cause[3]=1; without the macro, the same stimulus leaves outputs high and cause[3]=0.
REQ-035 SHALL cover mid-operation reset: rst_n_in pulsed low during RELEASE → all bits low immediately (no clock edge), cause=4'b0001, then the REQ-030 timing repeats.
